// File: rtl/coyote_req_mem.sv
// Request consumer behind the 2-port arbiter: queues requests in order, executes them
// against a resettable register memory, and returns read data tagged with the source id.
module coyote_req_mem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_rw,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_data,
    input  logic                   req_src,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_src,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_W;

    logic              fifo_rw_reg   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_reg [DEPTH];
    logic [DATA_W-1:0] fifo_data_reg [DEPTH];
    logic              fifo_src_reg  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              resp_valid_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_src_reg;
    logic [DATA_W-1:0] mem_reg [WORDS];

    logic              enq, deq, deq_read, mem_we, fifo_empty;
    logic              head_rw, head_src;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready depends only on the registered count, so a full FIFO refuses even on a dequeue cycle.
    assign req_ready  = (count_reg != CNT_W'(DEPTH));
    assign enq        = req_valid && req_ready;
    assign fifo_empty = (count_reg == '0);

    assign head_rw   = fifo_rw_reg[rd_ptr_reg];
    assign head_addr = fifo_addr_reg[rd_ptr_reg];
    assign head_data = fifo_data_reg[rd_ptr_reg];
    assign head_src  = fifo_src_reg[rd_ptr_reg];

    // Writes always retire; reads wait for a free response slot and block everything behind them.
    assign deq      = !fifo_empty && (head_rw || !resp_valid_reg || resp_ready);
    assign deq_read = deq && !head_rw;
    assign mem_we   = deq && head_rw;

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rw_reg[wr_ptr_reg]   <= req_rw;
            fifo_addr_reg[wr_ptr_reg] <= req_addr;
            fifo_data_reg[wr_ptr_reg] <= req_data;
            fifo_src_reg[wr_ptr_reg]  <= req_src;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_src_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (enq)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (deq)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (deq_read) begin
                resp_valid_reg <= 1'b1;
                resp_data_reg  <= mem_reg[head_addr];
                resp_src_reg   <= head_src;
            end else if (resp_ready) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

    // Flop-based memory so that reset can clear every word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++)
                mem_reg[i] <= '0;
        end else if (mem_we) begin
            mem_reg[head_addr] <= head_data;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_src   = resp_src_reg;
    assign fifo_count = count_reg;

endmodule
